// File: rtl/addsub_bcd_fnd_scan_pkg.sv
// calc_pkg: shared types and constants for the add/sub BCD FND block.
//   state_e     - control FSM states
//   SEG_*       - common-anode 7-segment glyphs {dp,g,f,e,d,c,b,a}, active-low
//   bcd_to_seg  - 4-bit BCD digit to glyph (non-decimal codes render blank)
//   dec_digits  - decimal digits needed for an unsigned value of 'bits' width
package calc_pkg;

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // ceil(bits * log10(2)) in integer arithmetic (log10(2) ~= 0.30103).
  function automatic int dec_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/addsub_bcd_fnd_scan_if.sv
// addsub_bcd_fnd_scan_if: operand/command inputs and display/status outputs.
//   i_start, i_mode, i_a, i_b  - command side (driven by master)
//   o_busy, o_done, o_c        - status
//   o_digit, o_font            - active-low FND digit enables and segments
interface addsub_bcd_fnd_scan_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic              i_start;
  logic              i_mode;
  logic [WIDTH-1:0]  i_a;
  logic [WIDTH-1:0]  i_b;
  logic              o_busy;
  logic              o_done;
  logic              o_c;
  logic [DIGITS-1:0] o_digit;
  logic [7:0]        o_font;

  modport master (output i_start, i_mode, i_a, i_b,
                  input  o_busy, o_done, o_c, o_digit, o_font);
  modport slave  (input  i_start, i_mode, i_a, i_b,
                  output o_busy, o_done, o_c, o_digit, o_font);
endinterface

// File: rtl/addsub_bcd_fnd_scan_mux.sv
// fnd_scan_mux: self-timed digit scanner for a common-anode FND.
//   i_clk, i_reset_n - clock, async active-low reset
//   i_bcd            - flat BCD value, digit i at [4i+3:4i]
//   i_blank          - per-digit blank mask (1 = dark)
//   i_sign           - show minus on the top digit
//   o_digit, o_font  - registered one-hot-low enable and segments
// Each tick presents the current index, then advances it, so digit 0 is the
// first digit lit after reset.
module fnd_scan_mux import calc_pkg::*; #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic [DIGITS-1:0]   i_blank,
  input  logic                i_sign,
  output logic [DIGITS-1:0]   o_digit,
  output logic [7:0]          o_font
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]     pre_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] digit_d, digit_q;
  logic [7:0]        font_d, font_q;
  logic [3:0]        nib;
  logic              tick;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));

  always_comb begin
    nib     = i_bcd[{idx_q, 2'b00} +: 4];
    digit_d = '1;
    digit_d[idx_q] = 1'b0;
    if (i_sign && idx_q == IW'(DIGITS - 1)) font_d = SEG_MINUS;
    else if (i_blank[idx_q])                font_d = SEG_BLANK;
    else                                    font_d = bcd_to_seg(nib);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      digit_q <= '1;
      font_q  <= SEG_BLANK;
    end else if (tick) begin
      pre_q   <= '0;
      idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      digit_q <= digit_d;
      font_q  <= font_d;
    end else begin
      pre_q   <= pre_q + 1'b1;
    end
  end

  assign o_digit = digit_q;
  assign o_font  = font_q;
endmodule

// File: rtl/addsub_bcd_fnd_scan.sv
// addsub_bcd_fnd_scan: registered WIDTH-bit add/sub, sequential double-dabble
// to BCD, and a self-scanning FND driver.
//   i_clk, i_reset_n - clock, async active-low reset
//   bus (slave)      - i_start/i_mode/i_a/i_b in; o_busy/o_done/o_c and
//                      o_digit/o_font out
// Build option SIGN_DISPLAY_EN: a borrowing subtract shows the magnitude with
// a minus glyph on the top digit; otherwise the raw WIDTH-bit difference is
// shown unsigned.
// Timeline after the edge that accepts i_start: CALC 1 cycle, CONV WIDTH+1
// cycles (one bit per cycle), DONE 1 cycle -> o_busy spans WIDTH+3 cycles.
module addsub_bcd_fnd_scan import calc_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  addsub_bcd_fnd_scan_if.slave bus
);
  localparam int VW = WIDTH + 1;       // display value width (add carries)
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VW + 1);

  // One digit beyond the value is reserved for the minus glyph.
  if (DIGITS < dec_digits(VW) + 1) begin : g_digits_chk
    $error("DIGITS too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              mode_q, c_q, neg_q, busy_q, done_q, disp_sign_q;
  logic [CW-1:0]     cnt_q;
  logic [BW+VW-1:0]  sh_q;             // {bcd, binary} double-dabble register
  logic [BW-1:0]     disp_q, adj;
  logic [VW-1:0]     sum, val;
  logic              neg, seen;
  logic [DIGITS-1:0] blank;

  // Subtract as a + ~b + 1, so sum[WIDTH] is the carry (1 = no borrow).
  assign sum = {1'b0, a_q} + {1'b0, b_q ^ {WIDTH{mode_q}}} + VW'(mode_q);

  always_comb begin
    val = sum;
    neg = 1'b0;
    if (mode_q) begin
`ifdef SIGN_DISPLAY_EN
      neg = ~sum[WIDTH];
      val = neg ? {1'b0, ~sum[WIDTH-1:0] + 1'b1} : {1'b0, sum[WIDTH-1:0]};
`else
      val = {1'b0, sum[WIDTH-1:0]};
`endif
    end
  end

  // Add-3 correction on every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    adj = sh_q[VW +: BW];
    for (int i = 0; i < DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = CALC;
      CALC:    state_d = CONV;
      CONV:    if (cnt_q == CW'(VW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      c_q         <= 1'b0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      disp_q      <= '0;
      disp_sign_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      case (state_q)
        IDLE: if (bus.i_start) begin
          a_q    <= bus.i_a;
          b_q    <= bus.i_b;
          mode_q <= bus.i_mode;
        end
        CALC: begin
          c_q   <= sum[WIDTH];
          neg_q <= neg;
          sh_q  <= {{BW{1'b0}}, val};
          cnt_q <= '0;
        end
        CONV: begin
          sh_q  <= {adj, sh_q[VW-1:0]} << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          disp_q      <= sh_q[VW +: BW];
          disp_sign_q <= neg_q;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking: dark above the most significant nonzero digit.
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) seen = 1'b1;
      blank[i] = ~seen;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_c    = c_q;

  fnd_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_bcd     (disp_q),
    .i_blank   (blank),
    .i_sign    (disp_sign_q),
    .o_digit   (bus.o_digit),
    .o_font    (bus.o_font)
  );
endmodule

// File: tb/tb_addsub_bcd_fnd_scan.sv
// Scoreboard bench for addsub_bcd_fnd_scan (WIDTH=8, DIGITS=4, SCAN_DIV=4).
// Stimulus pushes the model's expected carry and display glyphs; the monitor
// pops on o_done and checks every scanned digit against the current display.
// Expectations follow SIGN_DISPLAY_EN the same way the design build does.
module tb_addsub_bcd_fnd_scan;
  localparam int W = 8, D = 4, SD = 4;

  typedef struct packed {
    logic              c;
    logic [D-1:0][7:0] f;
    logic [31:0]       stamp;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  int unsigned cyc = 0;
  int checks = 0, passes = 0;
  exp_t q[$];
  exp_t tmp_e, m_e;
  logic [D-1:0][7:0] zero_disp, exp_disp, staged_disp;
  logic [D-1:0] prev_dig;
  bit staged;
  int busy_run, m_idx;

  addsub_bcd_fnd_scan_if #(.WIDTH(W), .DIGITS(D)) bus();

  addsub_bcd_fnd_scan #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic, decimal digits by division.
  function automatic exp_t model(input int a, input int b, input bit mode);
    logic [7:0] seg [10];
    exp_t e;
    int r, mag, p;
    bit neg;
    seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    e = '0;
    r = mode ? a - b : a + b;
    e.c = mode ? (r >= 0) : (r >= 2**W);
    neg = 0;
    mag = r;
    if (mode) begin
`ifdef SIGN_DISPLAY_EN
      neg = (r < 0);
      mag = neg ? -r : r;
`else
      mag = (r + 2**W) % (2**W);
`endif
    end
    p = 1;
    for (int i = 0; i < D; i++) begin
      e.f[i] = (i == 0 || mag >= p) ? seg[(mag / p) % 10] : 8'hFF;
      p = p * 10;
    end
    if (neg) e.f[D-1] = 8'hBF;
    return e;
  endfunction

  // Monitor: scoreboard pop on o_done, digit/font check on each scan step.
  always @(negedge clk) begin
    if (!rst_n) begin
      staged   = 0;
      exp_disp = zero_disp;
      prev_dig = '1;
      busy_run = 0;
    end else begin
      if (bus.o_digit !== prev_dig) begin
        m_idx = -1;
        for (int i = 0; i < D; i++) if (bus.o_digit === ~(D'(1) << i)) m_idx = i;
        chk("digit_onehot", 32'(m_idx >= 0), 1);
        if (m_idx >= 0) chk($sformatf("font_digit%0d", m_idx), bus.o_font, exp_disp[m_idx]);
      end
      prev_dig = bus.o_digit;
      // Display register loads one edge after o_done is seen.
      if (staged) begin exp_disp = staged_disp; staged = 0; end
      if (bus.o_busy) busy_run++;
      else if (busy_run != 0) begin chk("busy_width", busy_run, W + 3); busy_run = 0; end
      if (bus.o_done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          m_e = q.pop_front();
          chk("carry", bus.o_c, m_e.c);
          chk("latency", cyc - m_e.stamp, W + 3);
          staged_disp = m_e.f;
          staged = 1;
        end
      end
    end
  end

  task automatic issue(input int a, input int b, input bit mode);
    exp_t e;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_a     = W'(a);
    bus.i_b     = W'(b);
    bus.i_mode  = mode;
    e = model(a, b, mode);
    e.stamp = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Right after reset release: digit enables walk 0..3 and wrap, SD clocks apart.
  task automatic scan_check();
    logic [D-1:0] prev, expv;
    int n = 0;
    int unsigned last = 0;
    prev = bus.o_digit;
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      if (bus.o_digit !== prev) begin
        expv = ~(D'(1) << (n % D));
        chk("scan_seq", bus.o_digit, expv);
        if (n == 0) chk("scan_first_font", bus.o_font, 8'hC0);
        else        chk("scan_period", cyc - last, SD);
        last = cyc;
        prev = bus.o_digit;
        n++;
      end
    end
    if (n < 5) chk("scan_timeout", n, 5);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digit"}, bus.o_digit, 4'hF);
    chk({tag, "_font"},  bus.o_font,  8'hFF);
    chk({tag, "_busy"},  bus.o_busy,  0);
    chk({tag, "_done"},  bus.o_done,  0);
    chk({tag, "_c"},     bus.o_c,     0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    tmp_e = model(0, 0, 0);
    zero_disp = tmp_e.f;

    // 1: reset state, then scan of the zero display
    idle(3); #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    scan_check();

    // 2-4: directed ops, each left on display for a full scan
    issue(200, 100, 0); wait_done(); idle(20);
    issue(255, 255, 0); wait_done(); idle(20);
    issue(255, 0, 1);   wait_done(); idle(20);
    issue(5, 9, 1);     wait_done(); idle(20);

    // 5: start held high through the whole op; only the first is accepted
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_a = 8'd123; bus.i_b = 8'd45; bus.i_mode = 1'b0;
    tmp_e = model(123, 45, 0);
    tmp_e.stamp = cyc;
    q.push_back(tmp_e);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      bus.i_a = W'($urandom); bus.i_b = W'($urandom); bus.i_mode = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    idle(25);
    chk("pulse_single_done", q.size(), 0);

    // 6: reset during CONV, then normal operation resumes
    issue(200, 100, 0);
    idle(5); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("abort");
    idle(2); #1;
    rst_n = 1'b1;
    scan_check();
    issue(77, 200, 1); wait_done(); idle(20);

    // Random ops, mixing back-to-back starts and idle gaps
    for (int k = 0; k < 25; k++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 20)));
    end

    idle(30);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
